// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: FSM state codes, default width
// and the iteration-counter width helper.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FIXUP = 2'd3;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, subtract the divisor and keep the result if non-negative.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_msb;

  // The partial remainder can exceed half the divisor range, so the shifted
  // value keeps its top bit and the borrow sits one bit above that.
  assign shifted          = {partial_rem, in_bit};
  assign trial            = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit            = ~trial[WIDTH+1];
  assign rem_next         = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_trial_msb = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake, one quotient
// bit per clock. Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem (prem_q),
    .in_bit      (dvd_q[WIDTH-1]),
    .divisor     (dvs_q),
    .rem_next    (step_rem),
    .q_bit       (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          dbz_d = 1'b0;
          if (divisor == '0) begin
            // Zero divisor short-circuits straight to DONE with a flagged result.
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_RUN;
            prem_d  = '0;
            quo_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
            dvd_d   = magnitude(dividend);
            dvs_d   = magnitude(divisor);
            neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_d = dividend[WIDTH-1];
`else
            dvd_d   = dividend;
            dvs_d   = divisor;
`endif
          end
        end
      end
      ST_RUN: begin
        prem_d = step_rem;
        quo_d  = {quo_q[WIDTH-2:0], step_q};
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = ST_FIXUP;
`else
          state_d     = ST_DONE;
          quotient_d  = {quo_q[WIDTH-2:0], step_q};
          remainder_d = step_rem;
`endif
        end
      end
      ST_FIXUP: begin
        state_d = ST_DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
        // Truncation toward zero: quotient sign from the XOR, remainder follows the dividend.
        quotient_d  = neg_q_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_r_q ? (~prem_q + 1'b1) : prem_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  assign busy        = (state_q == ST_RUN) || (state_q == ST_FIXUP);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider against an arithmetic
// reference model (/ and %); also covers SEQ_DIVIDER_SIGNED_EN when defined.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [W-1:0] exp_q, exp_r, prev_q, prev_r;
  logic         exp_z, prev_z;
  int           exp_lat;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor convention.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
`endif
    if (b == 0) begin
      exp_q = '1; exp_r = a; exp_z = 1'b1; exp_lat = 0;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      exp_q = W'(sa / sb); exp_r = W'(sa % sb); exp_lat = W + 1;
`else
      exp_q = a / b; exp_r = a % b; exp_lat = W;
`endif
      exp_z = 1'b0;
    end
  endtask

  // Must be called at a negedge; returns just after the accepting posedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    model(a, b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    check({tag, "_busy0"}, busy, (exp_lat > 0));
    if (exp_lat > 0) begin
      check({tag, "_holdq"}, quotient, prev_q);
      check({tag, "_holdr"}, remainder, prev_r);
    end
    while (done !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_lat"}, cyc - start_cyc, exp_lat);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_z"}, div_by_zero, exp_z);
    check({tag, "_busydone"}, busy, 1'b0);
    prev_q = exp_q;
    prev_r = exp_r;
    prev_z = exp_z;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_z", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifndef SEQ_DIVIDER_SIGNED_EN
    launch(100, 7);
    wait_done("d100_7");
    check("d100_7_const_q", quotient, 14);
    check("d100_7_const_r", remainder, 2);
    @(negedge clk);
    check("idle_after_done", done, 1'b0);

    launch(16'hFFFF, 1);
    wait_done("dffff_1");
    @(negedge clk);
    launch(5, 9);
    wait_done("d5_9");

    @(negedge clk);
    launch(1234, 0);
    wait_done("d1234_0");
    check("d1234_0_const_r", remainder, 1234);
    @(negedge clk);
    launch(10, 3);
    wait_done("d10_3");
    check("d10_3_flagclr", div_by_zero, 1'b0);

    // Start pulse mid-run must be ignored.
    @(negedge clk);
    launch(1000, 3);
    repeat (4) @(negedge clk);
    dividend = 50; divisor = 5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = start_cyc;
    wait_done("d1000_3");
    check("d1000_3_const_q", quotient, 333);
    // Back-to-back start in the done cycle.
    launch(50, 5);
    wait_done("d50_5_b2b");
    check("d50_5_const_q", quotient, 10);
`else
    launch(16'hFFF9, 2);
    wait_done("sm7_2");
    check("sm7_2_const_q", quotient, 16'hFFFD);
    check("sm7_2_const_r", remainder, 16'hFFFF);
    @(negedge clk);
    launch(16'h8000, 16'hFFFF);
    wait_done("s8000_m1");
    check("s8000_m1_const_q", quotient, 16'h8000);
    check("s8000_m1_const_r", remainder, 0);
    @(negedge clk);
    launch(1234, 0);
    wait_done("s1234_0");
    launch(50, 5);
    wait_done("s50_5_b2b");
`endif

    // Asynchronous reset mid-run discards the result.
    @(negedge clk);
    launch(40000, 7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_z", div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    @(negedge clk);
    launch(9, 2);
    wait_done("d9_2");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    b = W'($urandom_range(1, 15));
        2, 3:    b = W'($urandom);
        4, 5:    b = W'($urandom_range(16'h8000, 16'hFFFF));
        6:       b = W'($urandom_range(1, 255));
        default: b = '0;
      endcase
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      launch(a, b);
      wait_done("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
